// File: rtl/debug_host_sequencer.sv
// Initiator for the MIPS debug UART link: sends start/program/run-mode bytes and captures dump frames.
// Optional rx gap watchdog enabled by defining DBG_HOST_TIMEOUT_EN.
module debug_host_sequencer #(
  parameter int LEN_DATA       = 8,
  parameter int CANT_INSTRUC   = 64,
  parameter int NUM_HDR_WORDS  = 6,
  parameter int CANT_REGS      = 32,
  parameter int CANT_MEM_DATOS = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            step_mode,
  input  logic                            step_req,
  input  logic                            stop,
  output logic [$clog2(CANT_INSTRUC)-1:0] prog_addr,
  input  logic [31:0]                     prog_data,
  output logic                            tx_start,
  output logic [LEN_DATA-1:0]             tx_data,
  input  logic                            tx_done,
  input  logic                            rx_done,
  input  logic [LEN_DATA-1:0]             rx_data,
  input  logic [5:0]                      cap_addr,
  output logic [31:0]                     cap_data,
  output logic                            busy,
  output logic                            frame_done,
  output logic [15:0]                     frame_count,
  output logic [1:0]                      err,
  output logic [6:0]                      state_out
);

  localparam int AW          = $clog2(CANT_INSTRUC);
  localparam int FRAME_WORDS = NUM_HDR_WORDS + CANT_REGS + CANT_MEM_DATOS;
  localparam int FRAME_BYTES = FRAME_WORDS * 4;
  localparam int RXW         = $clog2(FRAME_BYTES);

  localparam logic [LEN_DATA-1:0] CMD_START  = LEN_DATA'(8'h01);
  localparam logic [LEN_DATA-1:0] CMD_CONT   = LEN_DATA'(8'h02);
  localparam logic [LEN_DATA-1:0] CMD_STEP   = LEN_DATA'(8'h03);
  localparam logic [LEN_DATA-1:0] CMD_REPROG = LEN_DATA'(8'h05);
  localparam logic [LEN_DATA-1:0] CMD_NEXT   = LEN_DATA'(8'h06);

  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_SEND_CMD   = 7'b0000010,
    S_SEND_PROG  = 7'b0000100,
    S_SEND_MODE  = 7'b0001000,
    S_RECV_FRAME = 7'b0010000,
    S_WAIT_STEP  = 7'b0100000,
    S_DONE       = 7'b1000000
  } state_t;

  state_t              state_q;
  logic                tx_wait_q;
  logic                tx_start_q;
  logic [LEN_DATA-1:0] tx_data_q;
  logic                reprog_q;
  logic                mode_q;
  logic [1:0]          byte_sel_q;
  logic [AW-1:0]       prog_addr_q;
  logic [RXW-1:0]      rx_cnt_q;
  logic [23:0]         word_q;
  logic                frame_done_q;
  logic [15:0]         frame_count_q;
  logic [1:0]          err_q;
  logic [31:0]         cap_data_q;
  logic [31:0]         frame_buf [0:FRAME_WORDS-1];
  logic                buf_we;

`ifdef DBG_HOST_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap_q;
`endif

  // Handshake: a byte is issued (tx_start_q for one cycle, tx_wait_q set) only when
  // tx_wait_q is clear; tx_done while tx_wait_q is set retires it, so the next
  // tx_start can come no earlier than the cycle after tx_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_wait_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      reprog_q      <= 1'b0;
      mode_q        <= 1'b0;
      byte_sel_q    <= '0;
      prog_addr_q   <= '0;
      rx_cnt_q      <= '0;
      word_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= '0;
`ifdef DBG_HOST_TIMEOUT_EN
      gap_q         <= '0;
`endif
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DBG_HOST_TIMEOUT_EN
      if (state_q != S_RECV_FRAME) gap_q <= '0;
`endif
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            frame_count_q <= '0;
            err_q         <= '0;
            mode_q        <= step_mode;
            reprog_q      <= (state_q == S_DONE);
            tx_wait_q     <= 1'b0;
            state_q       <= S_SEND_CMD;
          end
        end
        S_SEND_CMD: begin
          if (!tx_wait_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= reprog_q ? CMD_REPROG : CMD_START;
            tx_wait_q  <= 1'b1;
          end else if (tx_done) begin
            tx_wait_q <= 1'b0;
            if (reprog_q) begin
              reprog_q <= 1'b0;
            end else begin
              prog_addr_q <= '0;
              byte_sel_q  <= '0;
              state_q     <= S_SEND_PROG;
            end
          end
        end
        S_SEND_PROG: begin
          if (!tx_wait_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= LEN_DATA'(prog_data[{byte_sel_q, 3'b000} +: 8]);
            tx_wait_q  <= 1'b1;
          end else if (tx_done) begin
            tx_wait_q  <= 1'b0;
            byte_sel_q <= byte_sel_q + 1'b1;
            if (byte_sel_q == 2'd3) begin
              // Opcode 6'h3F marks the halt word that terminates the program.
              if (prog_data[31:26] == 6'h3F) begin
                state_q <= S_SEND_MODE;
              end else if (prog_addr_q == AW'(CANT_INSTRUC - 1)) begin
                err_q[0] <= 1'b1;
                state_q  <= S_IDLE;
              end else begin
                prog_addr_q <= prog_addr_q + 1'b1;
              end
            end
          end
        end
        S_SEND_MODE: begin
          if (!tx_wait_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= mode_q ? CMD_STEP : CMD_CONT;
            tx_wait_q  <= 1'b1;
          end else if (tx_done) begin
            tx_wait_q <= 1'b0;
            rx_cnt_q  <= '0;
            state_q   <= mode_q ? S_WAIT_STEP : S_RECV_FRAME;
          end
        end
        S_WAIT_STEP: begin
          if (tx_wait_q) begin
            if (tx_done) begin
              tx_wait_q <= 1'b0;
              rx_cnt_q  <= '0;
              state_q   <= S_RECV_FRAME;
            end
          end else if (stop) begin
            state_q <= S_DONE;
          end else if (step_req) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= CMD_NEXT;
            tx_wait_q  <= 1'b1;
          end
        end
        S_RECV_FRAME: begin
          if (rx_done) begin
`ifdef DBG_HOST_TIMEOUT_EN
            gap_q <= '0;
`endif
            unique case (rx_cnt_q[1:0])
              2'd0:    word_q[7:0]   <= rx_data[7:0];
              2'd1:    word_q[15:8]  <= rx_data[7:0];
              2'd2:    word_q[23:16] <= rx_data[7:0];
              default: ;
            endcase
            if (rx_cnt_q == RXW'(FRAME_BYTES - 1)) begin
              rx_cnt_q      <= '0;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              state_q       <= mode_q ? S_WAIT_STEP : S_DONE;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
`ifdef DBG_HOST_TIMEOUT_EN
          else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
            err_q[1] <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The 4th byte of a word is merged straight from rx_data so the word lands on that strobe.
  assign buf_we = (state_q == S_RECV_FRAME) && rx_done && (rx_cnt_q[1:0] == 2'b11) && !reset;

  always_ff @(posedge clk) begin
    if (buf_we) frame_buf[rx_cnt_q[RXW-1:2]] <= {rx_data[7:0], word_q};
    if (cap_addr < 6'(FRAME_WORDS)) cap_data_q <= frame_buf[cap_addr];
  end

  assign prog_addr   = prog_addr_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign cap_data    = cap_data_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err         = err_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_debug_host_sequencer.sv
// Directed bench for debug_host_sequencer: UART tx responder, rx frame driver, program ROM model.
module tb_debug_host_sequencer;

  localparam logic [6:0] ST_IDLE  = 7'h01;
  localparam logic [6:0] ST_PROG  = 7'h04;
  localparam logic [6:0] ST_RECV  = 7'h10;
  localparam logic [6:0] ST_WSTEP = 7'h20;
  localparam logic [6:0] ST_DONE  = 7'h40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, step_mode = 1'b0, step_req = 1'b0, stop = 1'b0;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [5:0]  cap_addr = 6'd0;
  logic [31:0] cap_data;
  logic        busy, frame_done;
  logic [15:0] frame_count;
  logic [1:0]  err;
  logic [6:0]  state_out;

  logic [31:0] prog_mem [0:63];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  logic [31:0] rd;
  int          n;

  assign prog_data = prog_mem[prog_addr];

  debug_host_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .step_req(step_req), .stop(stop), .prog_addr(prog_addr), .prog_data(prog_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .rx_done(rx_done),
    .rx_data(rx_data), .cap_addr(cap_addr), .cap_data(cap_data), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .err(err), .state_out(state_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // UART transmitter model: logs each byte, answers tx_done a few cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_log.push_back(tx_data);
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [6:0] target, input int budget);
    int c = 0;
    while (state_out !== target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(state_out), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int nb, input int base);
    for (int k = 0; k < nb; k++) begin
      rx_data = 8'((k + base) & 255);
      rx_done = 1'b1;
      cyc(1);
      rx_done = 1'b0;
      cyc(1);
    end
  endtask

  task automatic read_cap(input logic [5:0] a, output logic [31:0] d);
    cap_addr = a;
    cyc(1);
    d = cap_data;
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < tx_log.size()) check(tag, 32'(tx_log[i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog_mem[i] = 32'h0;
    prog_mem[0] = 32'h00221820;
    prog_mem[1] = 32'hFC000000;

    // reset state
    cyc(3);
    check("rst_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_paddr", 32'(prog_addr), 32'd0);
    reset = 1'b0;
    cyc(1);

    // continuous session
    step_mode = 1'b0;
    start = 1'b1;
    check("busy_at_start", 32'(busy), 32'd0);
    cyc(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_state("cont_to_recv", ST_RECV, 500);
    exp_q = '{8'h01, 8'h20, 8'h18, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC, 8'h02};
    compare_tx("cont_tx");
    send_bytes(216, 0);
    check("cont_state", 32'(state_out), 32'(ST_DONE));
    check("cont_busy", 32'(busy), 32'd0);
    check("cont_fcount", 32'(frame_count), 32'd1);
    check("cont_fdone_pulses", 32'(fd_cnt), 32'd1);
    read_cap(6'd0, rd);
    check("cont_cap0", rd, 32'h03020100);
    read_cap(6'd1, rd);
    check("cont_cap1", rd, 32'h07060504);
    read_cap(6'd53, rd);
    check("cont_cap53", rd, 32'hD7D6D5D4);
    send_bytes(4, 8'h99);
    check("stray_rx_done_fc", 32'(frame_count), 32'd1);

    // step session from DONE (reprogram prefix)
    tx_log.delete();
    step_mode = 1'b1;
    pulse_start();
    check("step_fc_cleared", 32'(frame_count), 32'd0);
    wait_state("step_to_wait", ST_WSTEP, 500);
    exp_q = '{8'h05, 8'h01, 8'h20, 8'h18, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC, 8'h03};
    compare_tx("step_tx");
    send_bytes(5, 8'hAA);
    check("step_stray_state", 32'(state_out), 32'(ST_WSTEP));
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      cyc(1);
      step_req = 1'b0;
      wait_state("step_to_recv", ST_RECV, 100);
      send_bytes(216, 16 * i);
      check("step_back_wait", 32'(state_out), 32'(ST_WSTEP));
    end
    check("step_fcount", 32'(frame_count), 32'd3);
    check("step_fdone_pulses", 32'(fd_cnt), 32'd4);
    n = 0;
    foreach (tx_log[i]) if (tx_log[i] == 8'h06) n++;
    check("step_06_count", 32'(n), 32'd3);
    check("step_tx_len", 32'(tx_log.size()), 32'd14);
    read_cap(6'd0, rd);
    check("step_cap0", rd, 32'h23222120);
    read_cap(6'd53, rd);
    check("step_cap53", rd, 32'hF7F6F5F4);
    step_req = 1'b1;
    stop = 1'b1;
    cyc(1);
    step_req = 1'b0;
    stop = 1'b0;
    cyc(6);
    check("stop_wins_state", 32'(state_out), 32'(ST_DONE));
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_no_06", 32'(tx_log.size()), 32'd14);

    // program overflow: 64 words without halt
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    prog_mem[0] = 32'h0;
    prog_mem[1] = 32'h0;
    tx_log.delete();
    step_mode = 1'b0;
    pulse_start();
    wait_state("ovf_in_prog", ST_PROG, 100);
    wait_state("ovf_to_idle", ST_IDLE, 4000);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_tx_len", 32'(tx_log.size()), 32'd257);
    n = 0;
    foreach (tx_log[i]) if (tx_log[i] == 8'h02 || tx_log[i] == 8'h03) n++;
    check("ovf_no_mode", 32'(n), 32'd0);

    // reset mid-frame, then a clean frame
    prog_mem[0] = 32'h00221820;
    prog_mem[1] = 32'hFC000000;
    pulse_start();
    check("restart_err_clear", 32'(err), 32'd0);
    wait_state("mid_to_recv", ST_RECV, 500);
    send_bytes(100, 0);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_state", 32'(state_out), 32'(ST_IDLE));
    check("mid_rst_fc", 32'(frame_count), 32'd0);
    reset = 1'b0;
    cyc(1);
    pulse_start();
    wait_state("new_to_recv", ST_RECV, 500);
    send_bytes(216, 8'h40);
    check("new_state", 32'(state_out), 32'(ST_DONE));
    check("new_fcount", 32'(frame_count), 32'd1);
    read_cap(6'd0, rd);
    check("new_cap0", rd, 32'h43424140);
    read_cap(6'd24, rd);
    check("new_cap24", rd, 32'hA3A2A1A0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
